fine_peak_detect: RTL and testbench

- Consumes the 32-bit correlation magnitude from the fine-timing correlator and locates the fine timing peak of the preamble.
- Arms on a start pulse from coarse sync and searches a fixed window of valid samples for the maximum above a threshold.
- Reports the peak value and position with a one-cycle sync pulse, then blanks to reject repeated preamble echoes.
- Sits between the fine correlator and the symbol-boundary/FFT-window logic.

---
 rtl/fine_peak_detect.sv | 156 +++++++++++++++
 tb/tb_fine_peak_detect.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fine_peak_detect.sv
// Fine timing peak detector: finds the strongest correlation sample
// above threshold in a fixed window after an arm pulse.
module fine_peak_detect #(
  parameter int          WIN    = 64,
  parameter int          IDX_W  = 8,
  parameter logic [31:0] THRESH = 32'd50000000,
  parameter int          BLANK  = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [31:0]      corr,
  output logic             busy,
  output logic             sync,
  output logic             timeout,
  output logic [31:0]      peak_val,
  output logic [IDX_W-1:0] peak_idx,
  output logic [IDX_W-1:0] lag
);

  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam logic [IDX_W-1:0] WIN_LAST = IDX_W'(WIN - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_REPORT,
    S_BLANK
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic             found_q, found_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             sync_q, sync_d;
  logic             tmo_q, tmo_d;
  logic [31:0]      pval_q, pval_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic [IDX_W-1:0] lag_q, lag_d;

  logic             qual;
  logic [31:0]      new_val;
  logic [IDX_W-1:0] new_idx;
  logic             new_found;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      found_q   <= 1'b0;
      blk_q     <= '0;
      sync_q    <= 1'b0;
      tmo_q     <= 1'b0;
      pval_q    <= '0;
      pidx_q    <= '0;
      lag_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      found_q   <= found_d;
      blk_q     <= blk_d;
      sync_q    <= sync_d;
      tmo_q     <= tmo_d;
      pval_q    <= pval_d;
      pidx_q    <= pidx_d;
      lag_q     <= lag_d;
    end
  end

  // Next-state logic; the max update folds in the current sample so the
  // last window sample takes part in the report decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    found_d   = found_q;
    blk_d     = blk_q;
    sync_d    = 1'b0;
    tmo_d     = 1'b0;
    pval_d    = pval_q;
    pidx_d    = pidx_q;
    lag_d     = lag_q;

    qual      = (corr >= THRESH) &&
                (!found_q || (corr > max_val_q));
    new_val   = qual ? corr  : max_val_q;
    new_idx   = qual ? cnt_q : max_idx_q;
    new_found = found_q | qual;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SEARCH;
          cnt_d     = '0;
          max_val_d = '0;
          max_idx_d = '0;
          found_d   = 1'b0;
        end
      end
      S_SEARCH: begin
        if (en) begin
          max_val_d = new_val;
          max_idx_d = new_idx;
          found_d   = new_found;
          if (cnt_q == WIN_LAST) begin
            if (new_found) begin
              state_d = S_REPORT;
              sync_d  = 1'b1;
              pval_d  = new_val;
              pidx_d  = new_idx;
              lag_d   = WIN_LAST - new_idx;
            end else begin
              state_d = S_IDLE;
              tmo_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REPORT: begin
        blk_d   = '0;
        state_d = (BLANK == 0) ? S_IDLE : S_BLANK;
      end
      S_BLANK: begin
        if (en) begin
          if (blk_q == BLK_LAST) begin
            state_d = S_IDLE;
          end else begin
            blk_d = blk_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign sync     = sync_q;
  assign timeout  = tmo_q;
  assign peak_val = pval_q;
  assign peak_idx = pidx_q;
  assign lag      = lag_q;

endmodule

// File: tb/tb_fine_peak_detect.sv
// Scoreboard bench for fine_peak_detect: directed windows push expected
// reports, a monitor branch pops and compares on every sync/timeout.
module tb_fine_peak_detect;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [31:0] corr;
  logic        busy;
  logic        sync;
  logic        timeout;
  logic [31:0] peak_val;
  logic [7:0]  peak_idx;
  logic [7:0]  lag;

  fine_peak_detect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .corr     (corr),
    .busy     (busy),
    .sync     (sync),
    .timeout  (timeout),
    .peak_val (peak_val),
    .peak_idx (peak_idx),
    .lag      (lag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_sync;
    logic [31:0] v;
    logic [7:0]  idx;
    logic [7:0]  lag;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] w[64];
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               n, a, a, e, e);
    end
  endtask

  task automatic smp(input logic e, input logic [31:0] c,
                     input logic s);
    en    = e;
    corr  = c;
    start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 64; i++) w[i] = base;
  endtask

  // Arm, then play the window; en=1 garbage in the start cycle and
  // en=0 garbage in gaps must both be ignored.
  task automatic window(input bit gap, input bit is_sync,
                        input logic [31:0] ev, input logic [7:0] ei,
                        input logic [7:0] el);
    exp_t e;
    smp(1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 64; i++) begin
      if (gap && i > 0) begin
        smp(1'b0, 32'hFFFF_FFFF, 1'b0);
        smp(1'b0, 32'hFFFF_FFFF, 1'b0);
      end
      if (i == 63) begin
        e.is_sync = is_sync;
        e.v       = ev;
        e.idx     = ei;
        e.lag     = el;
        e.cyc     = cyc + 2;
        q.push_back(e);
      end
      smp(1'b1, w[i], 1'b0);
    end
    chk("busy_after_window", busy, is_sync ? 1 : 0);
  endtask

  // REPORT cycle then exactly 160 valid blanking samples.
  task automatic blank(input bit gap, input bit spam);
    smp(1'b1, 32'hFFFF_FFFF, spam);
    chk("busy_blank_entry", busy, 1);
    for (int j = 0; j < 160; j++) begin
      if (j == 159) chk("busy_blank_last", busy, 1);
      if (gap && (j % 5 == 0)) smp(1'b0, 32'hFFFF_FFFF, spam);
      smp(1'b1, 32'h0, spam && ((j % 7 == 0) || j == 159));
    end
    chk("busy_after_blank", busy, 0);
    smp(1'b0, 32'h0, 1'b0);
    chk("busy_idle_hold", busy, 0);
  endtask

  initial begin
    exp_t e;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    start  = 1'b0;
    corr   = 32'h0;
    fork
      begin : stim
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sync", sync, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_peak_val", peak_val, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_lag", lag, 0);
        rst_n = 1'b1;
        smp(1'b0, 32'h0, 1'b0);
        chk("idle_busy", busy, 0);

        fill(32'd1000);
        w[20] = 32'd60000000;
        window(1'b0, 1'b1, 32'd60000000, 8'd20, 8'd43);
        blank(1'b0, 1'b1);

        window(1'b1, 1'b1, 32'd60000000, 8'd20, 8'd43);
        blank(1'b1, 1'b0);

        fill(32'd1000);
        w[10] = 32'd70000000;
        w[30] = 32'd70000000;
        w[50] = 32'd69999999;
        window(1'b0, 1'b1, 32'd70000000, 8'd10, 8'd53);
        blank(1'b0, 1'b0);

        fill(32'd1000);
        w[63] = 32'd55000000;
        window(1'b0, 1'b1, 32'd55000000, 8'd63, 8'd0);
        blank(1'b0, 1'b0);

        fill(32'd1000);
        w[5]  = 32'd49999999;
        w[63] = 32'd49999999;
        window(1'b0, 1'b0, 32'd55000000, 8'd63, 8'd0);
        smp(1'b1, 32'd0, 1'b0);
        chk("busy_post_timeout", busy, 0);

        fill(32'd0);
        w[0] = 32'd50000000;
        w[1] = 32'd50000000;
        window(1'b0, 1'b1, 32'd50000000, 8'd0, 8'd63);
        blank(1'b0, 1'b0);

        smp(1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) smp(1'b1, 32'd90000000, 1'b0);
        chk("busy_mid_search", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_sync", sync, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_peak_val", peak_val, 0);
        chk("arst_peak_idx", peak_idx, 0);
        chk("arst_lag", lag, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        smp(1'b1, 32'd90000000, 1'b0);
        smp(1'b1, 32'd90000000, 1'b0);
        chk("idle_after_rst", busy, 0);

        fill(32'd1000);
        w[2]  = 32'h8000_0000;
        w[40] = 32'hFFFF_FFFF;
        w[41] = 32'hFFFF_FFFE;
        window(1'b0, 1'b1, 32'hFFFF_FFFF, 8'd40, 8'd23);
        blank(1'b0, 1'b1);
        repeat (3) smp(1'b0, 32'h0, 1'b0);
      end
      begin : mon
        forever begin
          @(negedge clk);
          cyc++;
          while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_pulse_cycle", cyc, e.cyc);
          end
          if (sync || timeout) begin
            if (q.size() == 0) begin
              chk("unexpected_sync", sync, 0);
              chk("unexpected_timeout", timeout, 0);
            end else begin
              e = q.pop_front();
              chk("pulse_cycle", cyc, e.cyc);
              chk("sync", sync, e.is_sync ? 1 : 0);
              chk("timeout", timeout, e.is_sync ? 0 : 1);
              chk("peak_val", peak_val, e.v);
              chk("peak_idx", peak_idx, e.idx);
              chk("lag", lag, e.lag);
            end
          end
        end
      end
    join_any
    chk("pending_expected", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
